// File: rtl/boolean_pkg.sv
// ============================================================================
// Module      : boolean_pkg
// Description : Shared types and elaboration helpers for the boolean sweeper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package boolean_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        DONE  = 2'd2
    } state_t;

    function automatic int table_width(input int n_in, input int n_out);
        return (1 << n_in) * n_out;
    endfunction

    function automatic bit params_legal(input int n_in, input int n_out, input int dwell);
        return (n_in >= 1) && (n_in <= 16) && (n_out >= 1) && (n_out <= 8) && (dwell >= 1);
    endfunction

endpackage

`default_nettype wire

// File: rtl/boolean_dwell_timer.sv
// ============================================================================
// Module      : boolean_dwell_timer
// Description : Counts DWELL enabled cycles and pulses tc on the last of them.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boolean_dwell_timer #(
    parameter int DWELL = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int                 c_CNT_W = $clog2(DWELL + 1);
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DWELL - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    assign tc = en && (r_cnt == c_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clr || tc) begin
            r_cnt <= '0;
        end else if (en) begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

endmodule

`default_nettype wire

// File: rtl/boolean_sweeper.sv
// ============================================================================
// Module      : boolean_sweeper
// Description : Exhaustive input sweep of a combinational function, capturing
//               its truth table and comparing it against an expected table.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module boolean_sweeper
    import boolean_pkg::*;
#(
    parameter int N_IN  = 3,
    parameter int N_OUT = 1,
    parameter int DWELL = 1
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                start,
    input  logic                                stop,
    input  logic                                mode_cont,
    input  logic [table_width(N_IN, N_OUT)-1:0] expected,
    input  logic [N_OUT-1:0]                    f_in,
    output logic [N_IN-1:0]                     vec_out,
    output logic                                busy,
    output logic                                done,
    output logic [table_width(N_IN, N_OUT)-1:0] table_out,
    output logic                                mismatch,
    output logic [N_IN-1:0]                     first_fail
);

    localparam int              c_TBL_W    = table_width(N_IN, N_OUT);
    localparam int              c_BASE_W   = $clog2(c_TBL_W);
    localparam logic [N_IN:0]   c_LAST_IDX = (N_IN + 1)'((1 << N_IN) - 1);
    localparam logic [N_IN:0]   c_IDX_ONE  = (N_IN + 1)'(1);

    if (!params_legal(N_IN, N_OUT, DWELL)) begin : g_bad_params
        $error("boolean_sweeper: parameters out of legal range");
    end

    state_t               r_state;
    logic [N_IN:0]        r_idx;
    logic [c_TBL_W-1:0]   r_work_table;
    logic                 r_work_mismatch;
    logic [N_IN-1:0]      r_work_ff;

    logic [N_IN-1:0]      r_vec_out;
    logic                 r_busy;
    logic                 r_done;
    logic [c_TBL_W-1:0]   r_table_out;
    logic                 r_mismatch;
    logic [N_IN-1:0]      r_first_fail;

    logic                 w_tc;
    logic                 w_timer_clr;
    logic                 w_begin;
    logic                 w_last;
    logic                 w_diff;
    logic                 w_mm_next;
    logic [N_IN-1:0]      w_ff_next;
    logic [N_IN:0]        w_idx_inc;
    logic [c_BASE_W-1:0]  w_base;
    logic [c_TBL_W-1:0]   w_table_next;

    assign w_timer_clr = (r_state != DRIVE) || stop;

    boolean_dwell_timer #(
        .DWELL (DWELL)
    ) u_dwell_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (w_timer_clr),
        .en    (r_state == DRIVE),
        .tc    (w_tc)
    );

    // Base is formed at 32 bits, then narrowed; the largest base always fits.
    assign w_base    = c_BASE_W'(32'(r_idx) * N_OUT);
    assign w_last    = (r_idx == c_LAST_IDX);
    assign w_idx_inc = r_idx + c_IDX_ONE;
    assign w_begin   = !stop && (((r_state == IDLE) && start) ||
                                 ((r_state == DONE) && mode_cont));

    // Next work state including the vector captured this cycle, so the final
    // capture can be published on the same edge.
    always_comb begin
        w_table_next                   = r_work_table;
        w_table_next[w_base +: N_OUT]  = f_in;
        w_diff                         = (f_in != expected[w_base +: N_OUT]);
        w_mm_next                      = r_work_mismatch || w_diff;
        w_ff_next                      = (!r_work_mismatch && w_diff) ? r_idx[N_IN-1:0] : r_work_ff;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_idx           <= '0;
            r_work_table    <= '0;
            r_work_mismatch <= 1'b0;
            r_work_ff       <= '0;
            r_vec_out       <= '0;
            r_busy          <= 1'b0;
            r_done          <= 1'b0;
            r_table_out     <= '0;
            r_mismatch      <= 1'b0;
            r_first_fail    <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_begin) begin
                r_state         <= DRIVE;
                r_idx           <= '0;
                r_vec_out       <= '0;
                r_busy          <= 1'b1;
                r_work_table    <= '0;
                r_work_mismatch <= 1'b0;
                r_work_ff       <= '0;
            end else if (stop || (r_state != DRIVE)) begin
                r_state   <= IDLE;
                r_vec_out <= '0;
                r_busy    <= 1'b0;
            end else if (w_tc) begin
                r_work_table    <= w_table_next;
                r_work_mismatch <= w_mm_next;
                r_work_ff       <= w_ff_next;
                if (w_last) begin
                    r_state      <= DONE;
                    r_busy       <= 1'b0;
                    r_done       <= 1'b1;
                    r_table_out  <= w_table_next;
                    r_mismatch   <= w_mm_next;
                    r_first_fail <= w_ff_next;
                end else begin
                    r_idx     <= w_idx_inc;
                    r_vec_out <= w_idx_inc[N_IN-1:0];
                end
            end
        end
    end

    assign vec_out    = r_vec_out;
    assign busy       = r_busy;
    assign done       = r_done;
    assign table_out  = r_table_out;
    assign mismatch   = r_mismatch;
    assign first_fail = r_first_fail;

endmodule

`default_nettype wire

// File: tb/tb_boolean_sweeper.sv
// ============================================================================
// Module      : tb_boolean_sweeper
// Description : Directed self-checking bench for boolean_sweeper (majority and
//               XOR functions, single-shot, continuous, stop and reset cases).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_boolean_sweeper;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;

    // DUT with DWELL=1 checking a 3-input majority function
    logic       start1     = 1'b0;
    logic       stop1      = 1'b0;
    logic       mode_cont1 = 1'b0;
    logic [7:0] expected1  = 8'hE8;
    logic       force_zero = 1'b0;
    logic       f_in1;
    logic [2:0] vec1;
    logic       busy1;
    logic       done1;
    logic [7:0] table1;
    logic       mm1;
    logic [2:0] ff1;

    // DUT with DWELL=3 checking a 3-input XOR
    logic       start3    = 1'b0;
    logic       stop3     = 1'b0;
    logic       mode_cont3 = 1'b0;
    logic [7:0] expected3 = 8'h96;
    logic       f_in3;
    logic [2:0] vec3;
    logic       busy3;
    logic       done3;
    logic [7:0] table3;
    logic       mm3;
    logic [2:0] ff3;

    int n_tests = 0;
    int n_fail  = 0;
    int c;

    always #5 clk = ~clk;

    assign f_in1 = force_zero ? 1'b0 : ((vec1[2] & vec1[1]) | (vec1[2] & vec1[0]) | (vec1[1] & vec1[0]));
    assign f_in3 = ^vec3;

    boolean_sweeper #(.N_IN(3), .N_OUT(1), .DWELL(1)) u_dut1 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start1),
        .stop       (stop1),
        .mode_cont  (mode_cont1),
        .expected   (expected1),
        .f_in       (f_in1),
        .vec_out    (vec1),
        .busy       (busy1),
        .done       (done1),
        .table_out  (table1),
        .mismatch   (mm1),
        .first_fail (ff1)
    );

    boolean_sweeper #(.N_IN(3), .N_OUT(1), .DWELL(3)) u_dut3 (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start3),
        .stop       (stop3),
        .mode_cont  (mode_cont3),
        .expected   (expected3),
        .f_in       (f_in3),
        .vec_out    (vec3),
        .busy       (busy3),
        .done       (done3),
        .table_out  (table3),
        .mismatch   (mm3),
        .first_fail (ff3)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Counts falling edges until done1 is seen, giving up after max_cyc.
    task automatic wait_done1(input int max_cyc, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done1 && (cyc < max_cyc));
    endtask

    task automatic run_single1(input logic [7:0] exp_tbl, input logic exp_mm, input logic [2:0] exp_ff);
        expected1 = exp_tbl;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        for (int i = 0; i < 8; i++) begin
            check_eq("vec_step", 32'(vec1), 32'(i));
            if (i == 7) check_eq("done_early", 32'(done1), 32'd0);
            @(negedge clk);
        end
        check_eq("done_at_8", 32'(done1), 32'd1);
        check_eq("busy_in_done", 32'(busy1), 32'd0);
        check_eq("table_maj", 32'(table1), 32'hE8);
        check_eq("mismatch", 32'(mm1), 32'(exp_mm));
        check_eq("first_fail", 32'(ff1), 32'(exp_ff));
        @(negedge clk);
        check_eq("done_one_cycle", 32'(done1), 32'd0);
        check_eq("vec_idle", 32'(vec1), 32'd0);
    endtask

    initial begin
        repeat (2) @(negedge clk);
        check_eq("rst_vec", 32'(vec1), 32'd0);
        check_eq("rst_busy", 32'(busy1), 32'd0);
        check_eq("rst_done", 32'(done1), 32'd0);
        check_eq("rst_table", 32'(table1), 32'd0);
        check_eq("rst_mm", 32'(mm1), 32'd0);
        check_eq("rst_ff", 32'(ff1), 32'd0);
        rst_n = 1'b1;

        // XOR with DWELL=3: every vector held three cycles, done 24 edges on
        @(negedge clk) start3 = 1'b1;
        @(negedge clk) start3 = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check_eq("dwell3_vec", 32'(vec3), 32'(i / 3));
            @(negedge clk);
        end
        check_eq("dwell3_done", 32'(done3), 32'd1);
        check_eq("dwell3_table", 32'(table3), 32'h96);
        check_eq("dwell3_mm", 32'(mm3), 32'd0);

        run_single1(8'hE8, 1'b0, 3'd0);
        run_single1(8'hE9, 1'b1, 3'd0);
        run_single1(8'h68, 1'b1, 3'd7);

        // stop beats start while idle
        @(negedge clk) begin start1 = 1'b1; stop1 = 1'b1; end
        @(negedge clk) begin start1 = 1'b0; stop1 = 1'b0; end
        check_eq("stop_wins_busy", 32'(busy1), 32'd0);

        // Continuous mode
        expected1  = 8'hE8;
        mode_cont1 = 1'b1;
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        wait_done1(20, c);
        check_eq("cont_latency", 32'(c), 32'd8);
        force_zero = 1'b1;
        wait_done1(20, c);
        check_eq("cont_period2", 32'(c), 32'd9);
        check_eq("cont2_table", 32'(table1), 32'h00);
        check_eq("cont2_mm", 32'(mm1), 32'd1);
        check_eq("cont2_ff", 32'(ff1), 32'd3);
        force_zero = 1'b0;
        wait_done1(20, c);
        check_eq("cont_period3", 32'(c), 32'd9);
        check_eq("cont3_table", 32'(table1), 32'hE8);
        check_eq("cont3_mm", 32'(mm1), 32'd0);
        check_eq("cont3_ff", 32'(ff1), 32'd0);

        // Abort the next sweep after four vectors, with a stray start inside
        force_zero = 1'b1;
        @(negedge clk);
        check_eq("abort_vec0", 32'(vec1), 32'd0);
        @(negedge clk);
        check_eq("abort_vec1", 32'(vec1), 32'd1);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check_eq("abort_vec2", 32'(vec1), 32'd2);
        @(negedge clk);
        check_eq("abort_vec3", 32'(vec1), 32'd3);
        stop1 = 1'b1;
        @(negedge clk);
        stop1      = 1'b0;
        mode_cont1 = 1'b0;
        force_zero = 1'b0;
        check_eq("abort_busy", 32'(busy1), 32'd0);
        check_eq("abort_vec", 32'(vec1), 32'd0);
        check_eq("abort_done", 32'(done1), 32'd0);
        check_eq("abort_table", 32'(table1), 32'hE8);
        check_eq("abort_mm", 32'(mm1), 32'd0);
        wait_done1(12, c);
        check_eq("abort_no_done", 32'(done1), 32'd0);

        // Asynchronous reset in the middle of a sweep
        @(negedge clk) start1 = 1'b1;
        @(negedge clk) start1 = 1'b0;
        repeat (5) @(negedge clk);
        check_eq("pre_rst_vec", 32'(vec1), 32'd5);
        #2 rst_n = 1'b0;
        #1;
        check_eq("arst_vec", 32'(vec1), 32'd0);
        check_eq("arst_busy", 32'(busy1), 32'd0);
        check_eq("arst_done", 32'(done1), 32'd0);
        check_eq("arst_table", 32'(table1), 32'd0);
        check_eq("arst_mm", 32'(mm1), 32'd0);
        check_eq("arst_ff", 32'(ff1), 32'd0);
        @(negedge clk) rst_n = 1'b1;
        run_single1(8'hE8, 1'b0, 3'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/boolean_sweeper.md
Name: boolean_sweeper

Overview:
- Parametrised, synthesizable exhaustive-sweep engine for combinational boolean functions.
- Steps an N_IN-bit input vector through all 2^N_IN combinations in ascending order, holding each vector for DWELL cycles.
- Captures the function's N_OUT output bits into a truth table and compares that table against an expected table.
- Instantiated beside any combinational boolean block, giving on-chip self-check of its truth table in single-shot or continuous mode.

Parameters:
- N_IN, 3, input-vector width; legal 1..16.
- N_OUT, 1, number of function output bits captured per vector; legal 1..8.
- DWELL, 1, cycles each vector is held; sampling occurs on the last of them; legal >=1.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  begin sweep; accepted only in IDLE.
- stop  in  1  abort sweep; returns to IDLE, nothing published.
- mode_cont  in  1  sampled in DONE: 1 = restart sweep immediately, 0 = return to IDLE.
- expected  in  (2^N_IN)*N_OUT  expected table; slice [k*N_OUT +: N_OUT] = outputs for vector k.
- f_in  in  N_OUT  function outputs driven back from the function under check.
- vec_out  out  N_IN  registered input vector to the function; MSB is the first operand.
- busy  out  1  high in DRIVE.
- done  out  1  one-cycle pulse on sweep completion.
- table_out  out  (2^N_IN)*N_OUT  last published truth table.
- mismatch  out  1  published table differs from expected.
- first_fail  out  N_IN  lowest mismatching vector index; 0 when mismatch=0.

Behaviour:
- Reset values: all outputs 0, including vec_out, table_out, mismatch, first_fail, done and busy; FSM in IDLE.
- FSM states: IDLE, DRIVE, DONE.
- IDLE:
  - vec_out=0.
  - start=1 → DRIVE with idx=0, dwell=0, work table cleared, work mismatch cleared.
- DRIVE:
  - vec_out=idx; dwell increments each cycle.
  - On the edge where dwell==DWELL-1:
    - capture f_in into work slice idx;
    - compare it against the expected slice; on the first difference, record idx as work first_fail and set work mismatch;
    - if idx==2^N_IN-1 → DONE; otherwise idx+1, dwell=0.
- DONE (exactly one cycle):
  - done=1, busy=0.
  - table_out, mismatch and first_fail are updated on the edge entering DONE, simultaneously with the final capture, so the last vector is included.
  - Exit: mode_cont=1 → DRIVE with a fresh sweep as from IDLE; else → IDLE.
- Latency: done is high in the cycle starting (2^N_IN)*DWELL edges after the start-accept edge.
  - Continuous mode: done period = (2^N_IN)*DWELL+1 cycles.
- start while in DRIVE or DONE: ignored.
- stop=1 in DRIVE or DONE → IDLE next edge; vec_out=0; published outputs retain their previous values; done suppressed in that cycle.
- stop and start both high in IDLE: stop wins, remain in IDLE.
- rst_n low at any time, including mid-sweep: all state and outputs clear immediately, with no wait for clk.
- Width rules:
  - idx is N_IN+1 bits so the terminal compare never wraps.
  - dwell counter width = $clog2(DWELL+1).
  - Table index = idx*N_OUT, computed at constant width with no truncation.
- expected must be stable for the duration of a sweep; it is sampled per vector, not latched.
- f_in is treated as combinational from vec_out and must settle within one cycle; DWELL>1 covers slower paths.

Decomposition:
- Package boolean_pkg holds:
  - the state enum (IDLE/DRIVE/DONE);
  - localparam function for table width, (2^N_IN)*N_OUT;
  - parameter legality checks as elaboration-time assertions.
- One natural sub-module: boolean_dwell_timer, a DWELL-cycle counter with clear and a terminal-count pulse. The FSM, capture and compare logic stay in the top.

Test Plan:
- N_IN=3, N_OUT=1, DWELL=1, f_in=3-input majority, expected=8'hE8, pulse start → vec_out steps 0..7 on consecutive cycles; done high 8 cycles after the start edge; table_out=8'hE8, mismatch=0, first_fail=0.
- Same setup, expected=8'hE9 → table_out=8'hE8, mismatch=1, first_fail=0. With expected=8'h68 → first_fail=7.
- DWELL=3, f_in=XOR of the three bits, expected=8'h96 → each vec_out held 3 cycles; done at start+24; table_out=8'h96.
- mode_cont=1, majority function → done pulses every 9 cycles. Forcing f_in=0 during sweep 2 → after sweep 2, mismatch=1, first_fail=3; after sweep 3 with f_in restored, mismatch=0.
- Stop after 4 vectors into sweep 2 → busy=0, vec_out=0 next cycle, no done pulse; table_out still 8'hE8 from sweep 1. start pulses during DRIVE have no effect on the idx sequence.
- rst_n asserted low mid-cycle during DRIVE at idx=5 → all outputs 0 before the next clk edge. After release, a fresh start completes a normal sweep with correct results.
